// File: rtl/npu_acc_pkg.sv
// Shared widths, FSM state type and saturation limits for the partial-sum
// accumulation stage.
package npu_acc_pkg;

    localparam int LANES = 16;
    localparam int IN_W  = 24;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;

    typedef enum logic {
        IDLE,
        BUSY
    } acc_state_t;

    // One guard bit above the accumulator so the rounding add cannot wrap.
    typedef logic signed [ACC_W:0] post_t;

    localparam post_t SAT_MAX = post_t'((2 ** (OUT_W - 1)) - 1);
    localparam post_t SAT_MIN = -post_t'(2 ** (OUT_W - 1));

endpackage

// File: rtl/psum_accumulator_if.sv
// PE-array input beat and Oagu-facing result word for the accumulation stage.
interface psum_accumulator_if;
    import npu_acc_pkg::*;

    logic [LANES*IN_W-1:0]  pe_data;
    logic                   pe_valid;
    logic [LANES*OUT_W-1:0] xpe_data;
    logic                   xpe_data_valid;

    modport master (
        output pe_data,
        output pe_valid,
        input  xpe_data,
        input  xpe_data_valid
    );

    modport slave (
        input  pe_data,
        input  pe_valid,
        output xpe_data,
        output xpe_data_valid
    );

endinterface

// File: rtl/acc_lane_post.sv
// Per-lane post-processing: round half up, arithmetic shift, optional ReLU,
// saturate to the signed output width.
module acc_lane_post
    import npu_acc_pkg::*;
(
    input  logic signed [ACC_W-1:0] sum_i,
    input  logic [4:0]              shift_i,
    input  logic                    relu_i,
    output logic signed [OUT_W-1:0] res_o
);

    post_t rnd;
    post_t shifted;
    post_t clamped;

    always_comb begin
        rnd     = (shift_i == 5'd0) ? '0 : (post_t'(1) <<< (shift_i - 5'd1));
        shifted = (post_t'(sum_i) + rnd) >>> shift_i;
        clamped = shifted;
        if (relu_i && shifted[ACC_W]) begin
            clamped = '0;
        end
        if (clamped > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (clamped < SAT_MIN) begin
            clamped = SAT_MIN;
        end
        res_o = clamped[OUT_W-1:0];
    end

endmodule

// File: rtl/psum_accumulator.sv
// Sums acc_count partial-sum beats per output pixel, post-processes each lane
// and emits one registered 256-bit result per group to Oagu.
module psum_accumulator
    import npu_acc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_calculate,
    input  logic [7:0]           acc_count,
    input  logic [15:0]          out_total,
    input  logic [4:0]           shift_amt,
    input  logic                 relu_en,
    psum_accumulator_if.slave    bus,
    output logic                 acc_done,
    output logic                 busy,
    output logic                 drop_err
);

    acc_state_t             state_q, state_d;
    logic [7:0]             acc_cnt_q, acc_cnt_d;
    logic [7:0]             beat_q, beat_d;
    logic [15:0]            out_total_q, out_total_d;
    logic [15:0]            out_cnt_q, out_cnt_d;
    logic [4:0]             shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic [ACC_W-1:0]       acc_q [LANES];
    logic [ACC_W-1:0]       acc_d [LANES];
    logic [ACC_W-1:0]       sum_w [LANES];
    logic [LANES*OUT_W-1:0] post_w;
    logic [LANES*OUT_W-1:0] xpe_data_q, xpe_data_d;
    logic                   xpe_valid_q, xpe_valid_d;
    logic                   acc_done_q, acc_done_d;
    logic                   drop_err_q, drop_err_d;
    logic                   last_beat;

    // Beat 0 of a group loads rather than adds, so the final sum of one group
    // and the first beat of the next can be back to back.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_w[i] = ((beat_q == '0) ? '0 : acc_q[i])
                     + {{(ACC_W-IN_W){bus.pe_data[IN_W*i+IN_W-1]}}, bus.pe_data[IN_W*i +: IN_W]};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        acc_lane_post u_post (
            .sum_i   (sum_w[g]),
            .shift_i (shift_q),
            .relu_i  (relu_q),
            .res_o   (post_w[OUT_W*g +: OUT_W])
        );
    end

    assign last_beat = (beat_q == (acc_cnt_q - 8'd1));

    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        beat_d      = beat_q;
        out_total_d = out_total_q;
        out_cnt_d   = out_cnt_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        acc_d       = acc_q;
        xpe_data_d  = xpe_data_q;
        xpe_valid_d = 1'b0;
        acc_done_d  = 1'b0;
        drop_err_d  = drop_err_q;

        unique case (state_q)
            IDLE: begin
                if (start_calculate) begin
                    acc_cnt_d   = (acc_count == '0) ? 8'd1 : acc_count;
                    out_total_d = out_total;
                    shift_d     = shift_amt;
                    relu_d      = relu_en;
                    beat_d      = '0;
                    out_cnt_d   = '0;
                    drop_err_d  = 1'b0;
                    if (out_total == '0) begin
                        acc_done_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (bus.pe_valid) begin
                    drop_err_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.pe_valid) begin
                    acc_d = sum_w;
                    if (last_beat) begin
                        beat_d      = '0;
                        xpe_data_d  = post_w;
                        xpe_valid_d = 1'b1;
                        out_cnt_d   = out_cnt_q + 16'd1;
                        if (out_cnt_d == out_total_q) begin
                            acc_done_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_cnt_q   <= '0;
            beat_q      <= '0;
            out_total_q <= '0;
            out_cnt_q   <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
            xpe_data_q  <= '0;
            xpe_valid_q <= 1'b0;
            acc_done_q  <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            beat_q      <= beat_d;
            out_total_q <= out_total_d;
            out_cnt_q   <= out_cnt_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            acc_q       <= acc_d;
            xpe_data_q  <= xpe_data_d;
            xpe_valid_q <= xpe_valid_d;
            acc_done_q  <= acc_done_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign bus.xpe_data       = xpe_data_q;
    assign bus.xpe_data_valid = xpe_valid_q;
    assign acc_done           = acc_done_q;
    assign busy               = (state_q == BUSY);
    assign drop_err           = drop_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: expected results are queued as stimulus
// is issued and a negedge monitor pops them whenever a result or done appears.
module tb_psum_accumulator;
    import npu_acc_pkg::*;

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        bit                     has_data;
        bit                     done;
        int unsigned            cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_calculate;
    logic [7:0]  acc_count;
    logic [15:0] out_total;
    logic [4:0]  shift_amt;
    logic        relu_en;
    logic        acc_done;
    logic        busy;
    logic        drop_err;

    int unsigned n_chk;
    int unsigned n_fail;
    int unsigned cyc;
    exp_t        sb[$];
    exp_t        e;

    psum_accumulator_if bus ();

    psum_accumulator dut (
        .clk             (clk),
        .rst             (rst),
        .start_calculate (start_calculate),
        .acc_count       (acc_count),
        .out_total       (out_total),
        .shift_amt       (shift_amt),
        .relu_en         (relu_en),
        .bus             (bus),
        .acc_done        (acc_done),
        .busy            (busy),
        .drop_err        (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [LANES*IN_W-1:0] pe_all(int v);
        logic [LANES*IN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[IN_W*i +: IN_W] = v[IN_W-1:0];
        return r;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] out_all(int v);
        logic [LANES*OUT_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[OUT_W*i +: OUT_W] = v[OUT_W-1:0];
        return r;
    endfunction

    // Result expected on the edge that samples the beat presented right now.
    task automatic push(input logic [LANES*OUT_W-1:0] d, input bit has, input bit dn);
        exp_t x;
        x.data = d; x.has_data = has; x.done = dn; x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic do_start(input logic [7:0] ac, input logic [15:0] ot,
                            input logic [4:0] sh, input logic re);
        start_calculate = 1'b1; acc_count = ac; out_total = ot; shift_amt = sh; relu_en = re;
        @(posedge clk); #1;
        start_calculate = 1'b0;
    endtask

    task automatic beat(input logic [LANES*IN_W-1:0] d);
        bus.pe_valid = 1'b1; bus.pe_data = d;
        @(posedge clk); #1;
        bus.pe_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.xpe_data_valid || acc_done)) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_output: got valid=%0b done=%0b at cycle %0d with nothing expected",
                         bus.xpe_data_valid, acc_done, cyc);
            end else begin
                e = sb.pop_front();
                check("out_cycle", 256'(cyc), 256'(e.cyc));
                check("out_valid", 256'(bus.xpe_data_valid), 256'(e.has_data));
                check("out_done", 256'(acc_done), 256'(e.done));
                if (e.has_data) check("out_data", bus.xpe_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d results pending", sb.size());
        $fatal(1);
    end

    initial begin
        logic [LANES*IN_W-1:0]  pv;
        logic [LANES*OUT_W-1:0] ov;
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; start_calculate = 1'b0; acc_count = '0; out_total = '0;
        shift_amt = '0; relu_en = 1'b0; bus.pe_valid = 1'b0; bus.pe_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_xpe_data", bus.xpe_data, '0);
        check("rst_valid", 256'(bus.xpe_data_valid), 256'(0));
        check("rst_done", 256'(acc_done), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_drop_err", 256'(drop_err), 256'(0));
        idle(1);

        // Single output of three beats.
        do_start(8'd3, 16'd1, 5'd0, 1'b0);
        check("start_busy", 256'(busy), 256'(1));
        beat(pe_all(1));
        beat(pe_all(2));
        push(out_all(6), 1, 1);
        beat(pe_all(3));
        idle(2);
        check("single_busy_after", 256'(busy), 256'(0));

        // Three back-to-back groups of two, no carry-over between groups.
        do_start(8'd2, 16'd3, 5'd0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            beat(pe_all(5));
            push(out_all(10), 1, g == 2);
            beat(pe_all(5));
        end
        idle(2);

        // Rounding, shift and saturation.
        do_start(8'd1, 16'd1, 5'd2, 1'b0);
        pv = '0;
        pv[IN_W*0 +: IN_W] = 24'd6;
        pv[IN_W*1 +: IN_W] = 24'hFFFFFA;
        pv[IN_W*2 +: IN_W] = 24'h7FFFFF;
        pv[IN_W*3 +: IN_W] = 24'h800000;
        pv[IN_W*4 +: IN_W] = 24'd5;
        pv[IN_W*5 +: IN_W] = 24'hFFFFFE;
        ov = '0;
        ov[OUT_W*0 +: OUT_W] = 16'd2;
        ov[OUT_W*1 +: OUT_W] = 16'hFFFF;
        ov[OUT_W*2 +: OUT_W] = 16'h7FFF;
        ov[OUT_W*3 +: OUT_W] = 16'h8000;
        ov[OUT_W*4 +: OUT_W] = 16'd1;
        ov[OUT_W*5 +: OUT_W] = 16'd0;
        push(ov, 1, 1);
        beat(pv);
        idle(2);

        // ReLU with saturation on the positive side.
        do_start(8'd1, 16'd1, 5'd0, 1'b1);
        pv = '0;
        pv[IN_W*0 +: IN_W] = 24'hFFFF9C;
        pv[IN_W*1 +: IN_W] = 24'd100;
        pv[IN_W*2 +: IN_W] = 24'hFF63C0;
        pv[IN_W*3 +: IN_W] = 24'd40000;
        pv[IN_W*4 +: IN_W] = 24'hFFFFFF;
        ov = '0;
        ov[OUT_W*1 +: OUT_W] = 16'd100;
        ov[OUT_W*3 +: OUT_W] = 16'h7FFF;
        push(ov, 1, 1);
        beat(pv);
        idle(2);
        check("hold_xpe_data", bus.xpe_data, ov);

        // acc_count 0 acts as 1; a start while busy must not change config.
        do_start(8'd0, 16'd2, 5'd0, 1'b0);
        push(out_all(7), 1, 0);
        beat(pe_all(7));
        do_start(8'd5, 16'd1, 5'd3, 1'b1);
        check("busy_ignore_start", 256'(busy), 256'(1));
        push(out_all(9), 1, 1);
        beat(pe_all(9));
        idle(2);

        // Beat while idle is dropped and flagged; next start clears the flag.
        beat(pe_all(4));
        check("drop_err_set", 256'(drop_err), 256'(1));
        idle(1);
        check("drop_err_sticky", 256'(drop_err), 256'(1));
        push('0, 0, 1);
        do_start(8'd1, 16'd0, 5'd0, 1'b0);
        check("drop_err_clear", 256'(drop_err), 256'(0));
        check("zero_total_idle", 256'(busy), 256'(0));
        idle(2);

        // Reset in the middle of a group.
        do_start(8'd3, 16'd1, 5'd0, 1'b0);
        beat(pe_all(1));
        rst = 1'b1;
        #1;
        check("midrst_xpe_data", bus.xpe_data, '0);
        check("midrst_valid", 256'(bus.xpe_data_valid), 256'(0));
        check("midrst_done", 256'(acc_done), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_drop_err", 256'(drop_err), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        do_start(8'd3, 16'd1, 5'd0, 1'b0);
        beat(pe_all(1));
        beat(pe_all(1));
        push(out_all(3), 1, 1);
        beat(pe_all(1));
        idle(3);

        check("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
